// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked serial adder (adder_serial).
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 32'sd1) / den;
  endfunction

endpackage

// File: rtl/adder_serial_chunk.sv
// One CHUNK_WIDTH-bit ripple add slice with carry in/out; reused every RUN cycle.
module adder_serial_chunk
  import adder_pkg::*;
#(
  parameter int CHUNK_WIDTH = 64
) (
  input  logic [CHUNK_WIDTH-1:0] a,
  input  logic [CHUNK_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [CHUNK_WIDTH-1:0] sum,
  output logic                   cout
);

  logic [CHUNK_WIDTH:0] total_s;

  // Widened add; the extra top bit is the chunk carry-out.
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {{CHUNK_WIDTH{1'b0}}, cin};
    sum     = total_s[CHUNK_WIDTH-1:0];
    cout    = total_s[CHUNK_WIDTH];
  end

endmodule

// File: rtl/adder_serial.sv
// Serial multi-chunk adder/subtractor: one CHUNK_WIDTH slice per cycle, valid/ready on both sides.
// Optional signed-overflow output ovf is enabled by defining ADDER_SERIAL_OVF_EN.
module adder_serial
  import adder_pkg::*;
#(
  parameter int IN_WIDTH    = 256,
  parameter int CHUNK_WIDTH = 64,
  parameter int SUB         = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] A,
  input  logic [IN_WIDTH-1:0] B,
  input  logic                Cin,
  output logic [IN_WIDTH-1:0] S,
  output logic                Cout,
`ifdef ADDER_SERIAL_OVF_EN
  output logic                ovf,
`endif
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int NOC    = ceil_div(IN_WIDTH, CHUNK_WIDTH);
  localparam int PAD_W  = NOC * CHUNK_WIDTH;
  localparam int LAST_W = ((IN_WIDTH % CHUNK_WIDTH) == 0) ? CHUNK_WIDTH : (IN_WIDTH % CHUNK_WIDTH);
  localparam int CNT_W  = (NOC > 1) ? $clog2(NOC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NOC - 1);

  state_e                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   carry_r;
  logic [PAD_W-1:0]       a_r;
  logic [PAD_W-1:0]       b_r;
  logic [PAD_W-1:0]       s_r;
  logic                   cout_r;
  logic                   out_valid_r;

  logic                   accept_s;
  logic                   last_s;
  logic [IN_WIDTH-1:0]    b_eff_s;
  logic                   carry_init_s;
  logic [CHUNK_WIDTH-1:0] chunk_sum_s;
  logic                   chunk_cout_s;
  logic                   last_carry_s;
  logic                   cout_next_s;
  logic [PAD_W-1:0]       s_shift_s;

`ifdef ADDER_SERIAL_OVF_EN
  logic                   ovf_r;
  logic                   ovf_next_s;
`endif

  // Ready while idle, or while the held result is being taken this cycle.
  always_comb begin
    if (state_r == IDLE) begin
      in_ready = 1'b1;
    end else if ((state_r == DONE) && out_ready) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

  assign accept_s = in_valid && in_ready;
  assign last_s   = (cnt_r == LAST_CNT);

  // Subtraction is A + ~B + 1, so the operand and initial carry are fixed at capture.
  always_comb begin
    if (SUB != 0) begin
      b_eff_s      = ~B;
      carry_init_s = 1'b1;
    end else begin
      b_eff_s      = B;
      carry_init_s = Cin;
    end
  end

  // Operands shift right one chunk per cycle, so the slice always reads the low chunk.
  adder_serial_chunk #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) u_chunk (
    .a   (a_r[CHUNK_WIDTH-1:0]),
    .b   (b_r[CHUNK_WIDTH-1:0]),
    .cin (carry_r),
    .sum (chunk_sum_s),
    .cout(chunk_cout_s)
  );

  // A short last chunk is zero-padded, so its carry appears just above its top bit.
  generate
    if (LAST_W == CHUNK_WIDTH) begin : g_full_last
      assign last_carry_s = chunk_cout_s;
    end else begin : g_part_last
      assign last_carry_s = chunk_sum_s[LAST_W];
    end
  endgenerate

  // Result chunks enter at the top; after NOC shifts chunk 0 sits at the LSB end.
  generate
    if (NOC == 1) begin : g_single
      assign s_shift_s = chunk_sum_s;
    end else begin : g_multi
      assign s_shift_s = {chunk_sum_s, s_r[PAD_W-1:CHUNK_WIDTH]};
    end
  endgenerate

  // Borrow-out is the complement of the final carry when subtracting.
  always_comb begin
    if (SUB != 0) begin
      cout_next_s = ~last_carry_s;
    end else begin
      cout_next_s = last_carry_s;
    end
  end

`ifdef ADDER_SERIAL_OVF_EN
  // Signed overflow: operand signs agree but the result sign differs.
  always_comb begin
    if ((a_r[LAST_W-1] == b_r[LAST_W-1]) && (chunk_sum_s[LAST_W-1] != a_r[LAST_W-1])) begin
      ovf_next_s = 1'b1;
    end else begin
      ovf_next_s = 1'b0;
    end
  end
`endif

  // Sequencer: capture on accept, one chunk per RUN cycle, hold the result in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {PAD_W{1'b0}};
      b_r         <= {PAD_W{1'b0}};
      s_r         <= {PAD_W{1'b0}};
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef ADDER_SERIAL_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        RUN: begin
          a_r     <= a_r >> CHUNK_WIDTH;
          b_r     <= b_r >> CHUNK_WIDTH;
          s_r     <= s_shift_s;
          carry_r <= chunk_cout_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            cout_r      <= cout_next_s;
`ifdef ADDER_SERIAL_OVF_EN
            ovf_r       <= ovf_next_s;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
      // Accept only happens in IDLE or on the DONE handshake, so it overrides those branches.
      if (accept_s) begin
        a_r     <= PAD_W'(A);
        b_r     <= PAD_W'(b_eff_s);
        carry_r <= carry_init_s;
        cnt_r   <= {CNT_W{1'b0}};
        state_r <= RUN;
      end
    end
  end

  assign S         = s_r[IN_WIDTH-1:0];
  assign Cout      = cout_r;
  assign out_valid = out_valid_r;
`ifdef ADDER_SERIAL_OVF_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_adder_serial.sv
// Self-checking bench for adder_serial: four configurations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_adder_serial;

  localparam int NOC_T [4] = '{4, 4, 2, 1};
  localparam int WID_T [4] = '{256, 256, 100, 256};
  localparam int SUB_T [4] = '{0, 1, 0, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [255:0] a_in, b_in;
  logic         cin_in;
  logic [3:0]   iv, ordy;
  logic         ir0, ir1, ir2, ir3;
  logic         ov0, ov1, ov2, ov3;
  logic         co0, co1, co2, co3;
  logic [255:0] s0, s1, s3;
  logic [99:0]  s2;
  logic [3:0]   ir_v, ov_v, co_v;
`ifdef ADDER_SERIAL_OVF_EN
  logic         ovf0, ovf1, ovf2, ovf3;
  logic [3:0]   ovf_v;
  assign ovf_v = {ovf3, ovf2, ovf1, ovf0};
`endif
  assign ir_v = {ir3, ir2, ir1, ir0};
  assign ov_v = {ov3, ov2, ov1, ov0};
  assign co_v = {co3, co2, co1, co0};

  int checks   = 0;
  int failures = 0;

  adder_serial #(.IN_WIDTH(256), .CHUNK_WIDTH(64), .SUB(0)) u_add (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir0), .A(a_in), .B(b_in), .Cin(cin_in),
    .S(s0), .Cout(co0),
`ifdef ADDER_SERIAL_OVF_EN
    .ovf(ovf0),
`endif
    .out_valid(ov0), .out_ready(ordy[0]));

  adder_serial #(.IN_WIDTH(256), .CHUNK_WIDTH(64), .SUB(1)) u_sub (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir1), .A(a_in), .B(b_in), .Cin(cin_in),
    .S(s1), .Cout(co1),
`ifdef ADDER_SERIAL_OVF_EN
    .ovf(ovf1),
`endif
    .out_valid(ov1), .out_ready(ordy[1]));

  adder_serial #(.IN_WIDTH(100), .CHUNK_WIDTH(64), .SUB(0)) u_w100 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir2), .A(a_in[99:0]), .B(b_in[99:0]), .Cin(cin_in),
    .S(s2), .Cout(co2),
`ifdef ADDER_SERIAL_OVF_EN
    .ovf(ovf2),
`endif
    .out_valid(ov2), .out_ready(ordy[2]));

  adder_serial #(.IN_WIDTH(256), .CHUNK_WIDTH(256), .SUB(0)) u_w1 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(ir3), .A(a_in), .B(b_in), .Cin(cin_in),
    .S(s3), .Cout(co3),
`ifdef ADDER_SERIAL_OVF_EN
    .ovf(ovf3),
`endif
    .out_valid(ov3), .out_ready(ordy[3]));

  function automatic logic [255:0] get_s(input logic [1:0] idx);
    case (idx)
      2'd0:    return s0;
      2'd1:    return s1;
      2'd2:    return {156'd0, s2};
      default: return s3;
    endcase
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    r = 256'd0;
    for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on W-bit unsigned values; overflow from 258-bit signed sum.
  task automatic model(input logic [1:0] idx, input logic [255:0] a_i, input logic [255:0] b_i, input logic cin,
                       output logic [255:0] s, output logic c, output logic v);
    logic [255:0] mask, a, b;
    logic [256:0] full;
    logic [257:0] r;
    int w;
    w    = WID_T[idx];
    mask = (w == 256) ? {256{1'b1}} : ((256'd1 << w) - 256'd1);
    a    = a_i & mask;
    b    = b_i & mask;
    if (SUB_T[idx] != 0) begin
      s = (a - b) & mask;
      c = (a < b);
      r = {{2{a[255]}}, a} - {{2{b[255]}}, b};
    end else begin
      full = {1'b0, a} + {1'b0, b} + {256'd0, cin};
      s    = full[255:0] & mask;
      c    = full[w];
      r    = {{2{a[255]}}, a} + {{2{b[255]}}, b} + {257'd0, cin};
    end
    v = !((r[257] == r[255]) && (r[256] == r[255]));
  endtask

  task automatic run_op(input logic [1:0] idx, input logic [255:0] a, input logic [255:0] b,
                        input logic cin, input logic hold, input string tag);
    logic [255:0] es;
    logic ec, ev;
    int k;
    model(idx, a, b, cin, es, ec, ev);
    a_in = a; b_in = b; cin_in = cin;
    iv[idx] = 1'b1; ordy[idx] = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 256'(ir_v[idx]), 256'd1);
    @(posedge clk); #1;
    iv[idx] = 1'b0;
    a_in = rnd256(); b_in = rnd256(); cin_in = 1'($urandom());
    if (hold) ordy[idx] = 1'b0;
    k = 0;
    while ((ov_v[idx] !== 1'b1) && (k < 40)) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 256'(k), 256'(NOC_T[idx]));
    chk({tag, "_S"}, get_s(idx), es);
    chk({tag, "_Cout"}, 256'(co_v[idx]), 256'(ec));
`ifdef ADDER_SERIAL_OVF_EN
    if (idx < 2'd2) chk({tag, "_ovf"}, 256'(ovf_v[idx]), 256'(ev));
`endif
    if (hold) begin
      repeat (10) begin
        @(posedge clk); #1;
        chk({tag, "_hold_S"}, get_s(idx), es);
        chk({tag, "_hold_Cout"}, 256'(co_v[idx]), 256'(ec));
        chk({tag, "_hold_valid"}, 256'(ov_v[idx]), 256'd1);
        chk({tag, "_hold_in_ready"}, 256'(ir_v[idx]), 256'd0);
      end
    end
  endtask

  initial begin
    logic seen;
    logic [255:0] ones;
    ones  = {256{1'b1}};
    reset = 1'b1; iv = 4'd0; ordy = 4'd0;
    a_in = 256'd0; b_in = 256'd0; cin_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_S", s0, 256'd0);
    chk("rst_Cout", 256'(co0), 256'd0);
    chk("rst_out_valid", 256'(ov0), 256'd0);
    chk("rst_in_ready", 256'(ir0), 256'd1);

    run_op(2'd0, ones, 256'd1, 1'b0, 1'b0, "add_wrap");
    run_op(2'd0, ones, ones, 1'b1, 1'b0, "add_max_cin");
    run_op(2'd1, 256'd5, 256'd7, 1'b0, 1'b0, "sub_5_7");
    run_op(2'd1, 256'd7, 256'd5, 1'b1, 1'b0, "sub_7_5");
    run_op(2'd1, 256'd9, 256'd9, 1'b0, 1'b0, "sub_equal");
    run_op(2'd2, (256'd1 << 100) - 256'd1, 256'd1, 1'b0, 1'b0, "w100_wrap");
    run_op(2'd3, ones, 256'd1, 1'b0, 1'b0, "w1_wrap");
`ifdef ADDER_SERIAL_OVF_EN
    run_op(2'd0, (256'd1 << 255) - 256'd1, 256'd1, 1'b0, 1'b0, "ovf_pos");
    run_op(2'd0, 256'd1, 256'd1, 1'b0, 1'b0, "ovf_none");
    run_op(2'd1, 256'd1 << 255, 256'd1, 1'b0, 1'b0, "ovf_sub");
`endif

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        run_op(2'(j), rnd256(), rnd256(), 1'($urandom()), 1'b0, "rand");
      end
    end

    // Backpressure, then a new operation accepted on the releasing edge.
    run_op(2'd0, rnd256(), rnd256(), 1'b1, 1'b1, "bp");
    run_op(2'd0, rnd256(), rnd256(), 1'b0, 1'b0, "bp_next");

    // Reset two chunks into an operation: no result may appear.
    a_in = rnd256(); b_in = rnd256(); iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_in_ready", 256'(ir0), 256'd1);
    chk("abort_S", s0, 256'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | ov0;
    end
    chk("abort_no_valid", 256'(seen), 256'd0);
    run_op(2'd0, 256'd3, 256'd4, 1'b0, 1'b0, "after_abort");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_serial.md
ADDER_SERIAL -- requirements
Module: adder_serial

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 256, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 64, bits added per cycle (1..IN_WIDTH).
REQ-003 SHALL have parameter SUB, default 0; 0 computes A+B+Cin, 1 computes A-B.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, operands presented.
REQ-007 SHALL have port in_ready, output, 1, block can accept operands.
REQ-008 SHALL have ports A and B, input, IN_WIDTH each, operands.
REQ-009 SHALL have port Cin, input, 1, carry-in; ignored when SUB=1.
REQ-010 SHALL have port S, output, IN_WIDTH, result.
REQ-011 SHALL have port Cout, output, 1, carry-out (SUB=1: borrow-out, 1 = A<B unsigned).
REQ-012 SHALL have port out_valid, output, 1, S/Cout valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts result.

Function
REQ-014 SHALL derive NoC = ceil(IN_WIDTH/CHUNK_WIDTH); the last chunk width is IN_WIDTH mod CHUNK_WIDTH when nonzero, else CHUNK_WIDTH.
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE; IDLE->RUN on accept; RUN->DONE after chunk NoC-1 is written; DONE->IDLE on out_valid&&out_ready without accept; DONE->RUN on that handshake plus accept.
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready); accept = in_valid && in_ready.
REQ-017 SHALL on accept latch A, B (bitwise inverted when SUB=1) and initial carry (SUB ? 1 : Cin), and clear chunk counter to 0.
REQ-018 SHALL in RUN, each cycle, write chunk k of S = A_k + B_k + carry and register the chunk carry-out as next carry; counter increments.
REQ-019 SHALL assert out_valid exactly NoC cycles after the accepting edge; latency NoC, throughput one result per NoC+1 cycles with out_ready=1.
REQ-020 SHALL hold S, Cout, out_valid stable in DONE until out_ready.
REQ-021 SHALL drive Cout = SUB ? ~carry : carry from final chunk carry.
REQ-022 SHALL ignore A, B, Cin, in_valid changes while in RUN.
REQ-023 SHALL with NoC==1 complete in one RUN cycle.

Reset
REQ-024 SHALL on reset force state IDLE, counter 0, carry 0, S=0, Cout=0, out_valid=0; in_ready=1 in the cycle following reset.
REQ-025 SHALL abort any in-flight operation on reset with no partial result emitted.

Configuration
REQ-026 SHALL, when ADDER_SERIAL_OVF_EN is defined, add output port ovf (1 bit) = signed two's-complement overflow of the full-width operation, valid with out_valid, reset 0.
REQ-027 SHALL, without ADDER_SERIAL_OVF_EN, have no ovf port and no associated logic.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, RUN, DONE) and a ceil-division function in shared package adder_pkg.
REQ-029 SHALL instantiate one combinational sub-module adder_serial_chunk (CHUNK_WIDTH-bit add with carry in/out) reused each cycle.

Verification (IN_WIDTH=256, CHUNK_WIDTH=64 unless noted)
REQ-030 SHALL test add: A=2^256-1, B=1, Cin=0 -> S=0, Cout=1, out_valid 4 cycles after accept.
REQ-031 SHALL test SUB=1: A=5, B=7 -> S=2^256-2, Cout=1; A=7, B=5 -> S=2, Cout=0.
REQ-032 SHALL test backpressure: out_ready=0 for 10 cycles in DONE -> S/Cout stable, in_ready=0; then out_ready=1 with in_valid=1 -> new operation accepted same cycle.
REQ-033 SHALL test reset asserted at counter=2 -> out_valid never rises for that op; next op A=3, B=4 -> S=7.
REQ-034 SHALL test IN_WIDTH=100, CHUNK_WIDTH=64: A=2^100-1, B=1 -> S=0, Cout=1 after 2 cycles; and CHUNK_WIDTH=256 -> latency 1.
REQ-035 SHALL test with ADDER_SERIAL_OVF_EN: A=2^255-1, B=1 add -> ovf=1; A=1, B=1 -> ovf=0.
